// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its two requesters
// (CPU MEM stage and DMA/loader) plus the single-port memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_ack_o;
    logic              cpu_stall_o;

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [DATA_W-1:0] dma_wdata_i;
    logic [DATA_W-1:0] dma_rdata_o;
    logic              dma_ack_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side: consumes requests, drives acks and the memory port.
    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_rdata_o, dma_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    // Environment side: requesters and the memory itself.
    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_rdata_o, dma_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port memory between the CPU MEM
// stage and a DMA/loader port, holds the memory enabled for MEM_LAT cycles
// per access, pulses a one-cycle ack afterwards and stalls the pipeline
// while a CPU request is outstanding. Keeps a saturating stall counter.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int CPU_PRIO = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_arbiter_if.master   bus,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state_r;
    logic [LAT_W-1:0]  cnt_r;
    logic              owner_r;
    logic              last_owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic              cpu_ack_r;
    logic              dma_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dma_rdata_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              req_any_s;
    logic              sel_owner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              start_s;
    logic              done_s;
    logic              stall_s;

    // Owner selection: single requester wins; on a tie either fixed CPU
    // priority or alternate away from the previous owner.
    always_comb begin
        sel_owner_s = OWN_CPU;
        req_any_s   = bus.cpu_req_i | bus.dma_req_i;
        if (bus.cpu_req_i && bus.dma_req_i) begin
            if (CPU_PRIO != 0) begin
                sel_owner_s = OWN_CPU;
            end else begin
                sel_owner_s = (last_owner_r == OWN_CPU) ? OWN_DMA : OWN_CPU;
            end
        end else if (bus.dma_req_i) begin
            sel_owner_s = OWN_DMA;
        end else begin
            sel_owner_s = OWN_CPU;
        end
    end

    // Request mux feeding the latch of the selected requester's command.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (sel_owner_s == OWN_DMA) begin
            sel_we_s    = bus.dma_we_i;
            sel_addr_s  = bus.dma_addr_i;
            sel_wdata_s = bus.dma_wdata_i;
        end else begin
            sel_we_s    = bus.cpu_we_i;
            sel_addr_s  = bus.cpu_addr_i;
            sel_wdata_s = bus.cpu_wdata_i;
        end
    end

    assign start_s = (state_r == ST_IDLE) && req_any_s;
    assign done_s  = (state_r == ST_ACCESS) && (cnt_r == LAT_ZERO);
    assign stall_s = bus.cpu_req_i & ~cpu_ack_r;

    // Sequencer: IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= LAT_ZERO;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DMA;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r      <= ST_ACCESS;
                        cnt_r        <= LAT_LOAD;
                        owner_r      <= sel_owner_s;
                        last_owner_r <= sel_owner_s;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == LAT_ZERO) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - LAT_ONE;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= LAT_ZERO;
                end
            endcase
        end
    end

    // Command latch: captured once at grant, requester inputs ignored after.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (start_s) begin
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end
    end

    // Memory strobes, registered so they are high exactly during ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
        end else if (start_s) begin
            mem_en_r <= 1'b1;
            mem_we_r <= sel_we_s;
        end else if (done_s) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
        end
    end

    // Response: one-cycle ack to the owner, read data held until next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
            dma_rdata_r <= {DATA_W{1'b0}};
        end else begin
            cpu_ack_r <= 1'b0;
            dma_ack_r <= 1'b0;
            if (done_s) begin
                if (owner_r == OWN_DMA) begin
                    dma_ack_r <= 1'b1;
                    if (!we_r) begin
                        dma_rdata_r <= bus.mem_rdata_i;
                    end
                end else begin
                    cpu_ack_r <= 1'b1;
                    if (!we_r) begin
                        cpu_rdata_r <= bus.mem_rdata_i;
                    end
                end
            end
        end
    end

    // Saturating count of cycles the pipeline is stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.cpu_ack_o   = cpu_ack_r;
    assign bus.dma_ack_o   = dma_ack_r;
    assign bus.cpu_rdata_o = cpu_rdata_r;
    assign bus.dma_rdata_o = dma_rdata_r;
    assign bus.cpu_stall_o = stall_s;
    assign bus.mem_en_o    = mem_en_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = addr_r;
    assign bus.mem_wdata_o = wdata_r;
    assign busy_o          = (state_r != ST_IDLE);
    assign stall_cnt_o     = stall_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=2 round-robin 32-bit
// counter; MEM_LAT=1 CPU-priority 4-bit counter) driven by requester agents
// and checked every cycle against a transaction-timing reference model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_init;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    logic        busy0, busy1;
    logic [31:0] scnt0;
    logic [3:0]  scnt1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .CPU_PRIO(0), .CNT_W(32)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0), .busy_o(busy0), .stall_cnt_o(scnt0));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CPU_PRIO(1), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1), .busy_o(busy1), .stall_cnt_o(scnt1));

    // Requester drive state, index [dut][0=cpu,1=dma]
    logic        req_v   [2][2];
    logic        we_v    [2][2];
    logic [31:0] addr_v  [2][2];
    logic [31:0] wdata_v [2][2];

    assign bus0.cpu_req_i = req_v[0][0];  assign bus0.dma_req_i = req_v[0][1];
    assign bus0.cpu_we_i  = we_v[0][0];   assign bus0.dma_we_i  = we_v[0][1];
    assign bus0.cpu_addr_i = addr_v[0][0]; assign bus0.dma_addr_i = addr_v[0][1];
    assign bus0.cpu_wdata_i = wdata_v[0][0]; assign bus0.dma_wdata_i = wdata_v[0][1];
    assign bus1.cpu_req_i = req_v[1][0];  assign bus1.dma_req_i = req_v[1][1];
    assign bus1.cpu_we_i  = we_v[1][0];   assign bus1.dma_we_i  = we_v[1][1];
    assign bus1.cpu_addr_i = addr_v[1][0]; assign bus1.dma_addr_i = addr_v[1][1];
    assign bus1.cpu_wdata_i = wdata_v[1][0]; assign bus1.dma_wdata_i = wdata_v[1][1];

    // Behavioural memories (word-indexed by address bits [7:2])
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'd5;
        if (i == 2) return 32'd10;
        return 32'(i) * 32'd7 + 32'd100;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= init_word(i);
                mem1[i] <= init_word(i);
            end
        end else begin
            if (bus0.mem_en_o && bus0.mem_we_o) mem0[bus0.mem_addr_o[7:2]] <= bus0.mem_wdata_o;
            if (bus1.mem_en_o && bus1.mem_we_o) mem1[bus1.mem_addr_o[7:2]] <= bus1.mem_wdata_o;
        end
    end

    assign bus0.mem_rdata_i = bus0.mem_en_o ? mem0[bus0.mem_addr_o[7:2]] : 32'd0;
    assign bus1.mem_rdata_i = bus1.mem_en_o ? mem1[bus1.mem_addr_o[7:2]] : 32'd0;

    // Observed outputs
    logic        o_cack [2], o_dack [2], o_men [2], o_mwe [2], o_busy [2], o_stall [2];
    logic [31:0] o_crd [2], o_drd [2], o_maddr [2], o_mwd [2], o_scnt [2];

    assign o_cack[0] = bus0.cpu_ack_o;   assign o_cack[1] = bus1.cpu_ack_o;
    assign o_dack[0] = bus0.dma_ack_o;   assign o_dack[1] = bus1.dma_ack_o;
    assign o_men[0]  = bus0.mem_en_o;    assign o_men[1]  = bus1.mem_en_o;
    assign o_mwe[0]  = bus0.mem_we_o;    assign o_mwe[1]  = bus1.mem_we_o;
    assign o_busy[0] = busy0;            assign o_busy[1] = busy1;
    assign o_stall[0] = bus0.cpu_stall_o; assign o_stall[1] = bus1.cpu_stall_o;
    assign o_crd[0]  = bus0.cpu_rdata_o; assign o_crd[1]  = bus1.cpu_rdata_o;
    assign o_drd[0]  = bus0.dma_rdata_o; assign o_drd[1]  = bus1.dma_rdata_o;
    assign o_maddr[0] = bus0.mem_addr_o; assign o_maddr[1] = bus1.mem_addr_o;
    assign o_mwd[0]  = bus0.mem_wdata_o; assign o_mwd[1]  = bus1.mem_wdata_o;
    assign o_scnt[0] = scnt0;            assign o_scnt[1] = {28'd0, scnt1};

    // Reference model: each access is a transaction granted at cycle g,
    // occupying the memory in g+1..g+L with its ack in g+L+1; the arbiter
    // is free again from g+L+2.
    int          L [2];
    bit          prio [2];
    longint      cmax [2];
    int          gcyc [2];
    int          free_at [2];
    bit          own [2];
    bit          last_own [2];
    bit          t_we [2];
    logic [31:0] t_addr [2], t_wdata [2], t_rval [2];
    logic [31:0] exp_rd [2][2];
    longint      exp_cnt [2];
    logic [31:0] refm [2][64];
    bit          pend [2][2];
    int          last_ack [2][2];
    int          log0 [$];
    int          log1 [$];

    int cyc;
    int mode;          // 0 manual, 1 continuous, 2 random
    bit cont_mask [2];
    int errors;
    int checks;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d got=%h want=%h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic issue(input int d, input int r, input bit we, input logic [31:0] a, input logic [31:0] wd);
        req_v[d][r] = 1'b1; we_v[d][r] = we; addr_v[d][r] = a; wdata_v[d][r] = wd; pend[d][r] = 1'b1;
    endtask

    task automatic drive(input int d);
        bit served;
        logic [31:0] a;
        for (int r = 0; r < 2; r++) begin
            served = pend[d][r] && (int'(own[d]) == r) && (cyc > gcyc[d]) && (cyc <= gcyc[d] + L[d]);
            if (pend[d][r]) begin
                if (mode == 2 && served) begin
                    if ($urandom_range(0, 2) == 0) begin
                        we_v[d][r] = 1'($urandom_range(0, 1)); addr_v[d][r] = $urandom; wdata_v[d][r] = $urandom;
                    end
                    if ($urandom_range(0, 7) == 0) req_v[d][r] = 1'b0;
                end
            end else begin
                req_v[d][r] = 1'b0;
                if ((mode == 1 && cont_mask[r]) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
                    a = $urandom; a[1:0] = 2'b00;
                    issue(d, r, 1'($urandom_range(0, 1)), a, $urandom);
                end
            end
        end
    endtask

    task automatic check_dut(input int d);
        bit acc, ackn, bsy;
        acc  = (cyc >= gcyc[d] + 1) && (cyc <= gcyc[d] + L[d]);
        ackn = (cyc == gcyc[d] + L[d] + 1);
        bsy  = (cyc > gcyc[d]) && (cyc <= gcyc[d] + L[d] + 1);
        if (ackn && !t_we[d]) exp_rd[d][own[d]] = t_rval[d];
        chk("mem_en", d, 32'(o_men[d]), 32'(acc));
        if (acc) begin
            chk("mem_we", d, 32'(o_mwe[d]), 32'(t_we[d]));
            chk("mem_addr", d, o_maddr[d], t_addr[d]);
            if (t_we[d]) chk("mem_wdata", d, o_mwd[d], t_wdata[d]);
        end
        chk("cpu_ack", d, 32'(o_cack[d]), 32'(ackn && own[d] == 1'b0));
        chk("dma_ack", d, 32'(o_dack[d]), 32'(ackn && own[d] == 1'b1));
        chk("cpu_rdata", d, o_crd[d], exp_rd[d][0]);
        chk("dma_rdata", d, o_drd[d], exp_rd[d][1]);
        chk("busy", d, 32'(o_busy[d]), 32'(bsy));
        chk("stall", d, 32'(o_stall[d]), 32'(req_v[d][0] && !(ackn && own[d] == 1'b0)));
        chk("stall_cnt", d, o_scnt[d], 32'(exp_cnt[d]));
        if (o_cack[d] === 1'b1) begin
            last_ack[d][0] = cyc;
            if (d == 0) log0.push_back(0); else log1.push_back(0);
        end
        if (o_dack[d] === 1'b1) begin
            last_ack[d][1] = cyc;
            if (d == 0) log0.push_back(1); else log1.push_back(1);
        end
    endtask

    task automatic model_update(input int d, input bit do_rst);
        bit ackn;
        int o;
        ackn = (cyc == gcyc[d] + L[d] + 1);
        if (do_rst) begin
            gcyc[d] = -100; free_at[d] = cyc + 1; last_own[d] = 1'b1;
            exp_rd[d][0] = 32'd0; exp_rd[d][1] = 32'd0; exp_cnt[d] = 0;
            pend[d][0] = 1'b0; pend[d][1] = 1'b0;
        end else begin
            if (req_v[d][0] && !(ackn && own[d] == 1'b0) && exp_cnt[d] < cmax[d]) exp_cnt[d]++;
            if (ackn) pend[d][own[d]] = 1'b0;
            if (cyc >= free_at[d] && (req_v[d][0] || req_v[d][1])) begin
                if (req_v[d][0] && req_v[d][1]) o = prio[d] ? 0 : (last_own[d] ? 0 : 1);
                else o = req_v[d][1] ? 1 : 0;
                gcyc[d] = cyc; free_at[d] = cyc + L[d] + 2;
                own[d] = 1'(o); last_own[d] = 1'(o);
                t_we[d] = we_v[d][o]; t_addr[d] = addr_v[d][o]; t_wdata[d] = wdata_v[d][o];
                if (t_we[d]) refm[d][t_addr[d][7:2]] = t_wdata[d];
                else t_rval[d] = refm[d][t_addr[d][7:2]];
            end
        end
    endtask

    task automatic run_cycle(input bit do_rst);
        rst = do_rst;
        for (int d = 0; d < 2; d++) drive(d);
        #1;
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int d = 0; d < 2; d++) model_update(d, do_rst);
        @(negedge clk);
        cyc++;
    endtask

    function automatic bit any_pend();
        return pend[0][0] | pend[0][1] | pend[1][0] | pend[1][1];
    endfunction

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (any_pend() && n < maxc) begin
            run_cycle(1'b0);
            n++;
        end
        chk("drain_timeout", 0, 32'(any_pend()), 32'd0);
    endtask

    initial begin
        int c0;
        int exp0 [4];
        int exp1 [4];
        rst = 1'b1; mem_init = 1'b1; mode = 0; cyc = 0; errors = 0; checks = 0;
        cont_mask[0] = 1'b0; cont_mask[1] = 1'b0;
        L[0] = 2; L[1] = 1; prio[0] = 1'b0; prio[1] = 1'b1;
        cmax[0] = 64'd4294967295; cmax[1] = 64'd15;
        for (int d = 0; d < 2; d++) begin
            gcyc[d] = -100; free_at[d] = 0; last_own[d] = 1'b1; own[d] = 1'b0;
            t_we[d] = 1'b0; t_addr[d] = 32'd0; t_wdata[d] = 32'd0; t_rval[d] = 32'd0;
            exp_cnt[d] = 0;
            for (int r = 0; r < 2; r++) begin
                req_v[d][r] = 1'b0; we_v[d][r] = 1'b0; addr_v[d][r] = 32'd0; wdata_v[d][r] = 32'd0;
                pend[d][r] = 1'b0; exp_rd[d][r] = 32'd0; last_ack[d][r] = -1;
            end
            for (int i = 0; i < 64; i++) refm[d][i] = init_word(i);
        end
        @(negedge clk);
        run_cycle(1'b1);
        run_cycle(1'b1);
        mem_init = 1'b0;
        run_cycle(1'b0);

        // CPU read alone of word 0x08
        for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 32'h08, 32'd0);
        c0 = cyc;
        wait_idle(20);
        chk("t1_ack_cyc", 0, 32'(last_ack[0][0]), 32'(c0 + 3));
        chk("t1_ack_cyc", 1, 32'(last_ack[1][0]), 32'(c0 + 2));
        chk("t1_rdata", 0, o_crd[0], 32'd10);
        chk("t1_rdata", 1, o_crd[1], 32'd10);
        chk("t1_stall_cnt", 0, o_scnt[0], 32'd3);
        chk("t1_stall_cnt", 1, o_scnt[1], 32'd2);

        // DMA write 77 to 0x14, then CPU reads it back
        for (int d = 0; d < 2; d++) issue(d, 1, 1'b1, 32'h14, 32'd77);
        c0 = cyc;
        wait_idle(20);
        chk("t2_dack_cyc", 0, 32'(last_ack[0][1]), 32'(c0 + 3));
        chk("t2_dack_cyc", 1, 32'(last_ack[1][1]), 32'(c0 + 2));
        for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 32'h14, 32'd0);
        wait_idle(20);
        chk("t2_rdata", 0, o_crd[0], 32'd77);
        chk("t2_rdata", 1, o_crd[1], 32'd77);

        // Simultaneous CPU read and DMA write straight after reset
        run_cycle(1'b1);
        for (int d = 0; d < 2; d++) begin
            issue(d, 0, 1'b0, 32'h00, 32'd0);
            issue(d, 1, 1'b1, 32'h20, 32'd99);
        end
        c0 = cyc;
        wait_idle(30);
        chk("t3_cack_cyc", 0, 32'(last_ack[0][0]), 32'(c0 + 3));
        chk("t3_dack_cyc", 0, 32'(last_ack[0][1]), 32'(c0 + 7));
        chk("t3_cack_cyc", 1, 32'(last_ack[1][0]), 32'(c0 + 2));
        chk("t3_dack_cyc", 1, 32'(last_ack[1][1]), 32'(c0 + 5));
        chk("t3_rdata", 0, o_crd[0], 32'd5);
        chk("t3_rdata", 1, o_crd[1], 32'd5);

        // Both requesters held continuously: grant order
        log0.delete(); log1.delete();
        mode = 1; cont_mask[0] = 1'b1; cont_mask[1] = 1'b1;
        for (int n = 0; n < 60 && (log0.size() < 4 || log1.size() < 4); n++) run_cycle(1'b0);
        mode = 0;
        wait_idle(30);
        exp0 = '{0, 1, 0, 1};
        exp1 = '{0, 0, 0, 0};
        chk("t4_len", 0, 32'(log0.size() >= 4), 32'd1);
        chk("t4_len", 1, 32'(log1.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < log0.size()) chk("t4_order", 0, 32'(log0[i]), 32'(exp0[i]));
            if (i < log1.size()) chk("t4_order", 1, 32'(log1[i]), 32'(exp1[i]));
        end

        // CPU stalls long enough to saturate the 4-bit counter
        mode = 1; cont_mask[0] = 1'b1; cont_mask[1] = 1'b0;
        for (int n = 0; n < 40; n++) run_cycle(1'b0);
        mode = 0;
        wait_idle(20);
        chk("t5_sat", 1, o_scnt[1], 32'd15);
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("t5_sat_hold", 1, o_scnt[1], 32'd15);

        // Reset in the second cycle of a DMA write
        run_cycle(1'b1);
        for (int d = 0; d < 2; d++) issue(d, 1, 1'b1, 32'h30, 32'h0000ABCD);
        c0 = cyc;
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t6_dack", d, 32'(o_dack[d]), 32'd0);
            chk("t6_mem_en", d, 32'(o_men[d]), 32'd0);
            chk("t6_busy", d, 32'(o_busy[d]), 32'd0);
            chk("t6_stall_cnt", d, o_scnt[d], 32'd0);
        end
        chk("t6_cyc", 0, 32'(cyc), 32'(c0 + 3));
        run_cycle(1'b0);
        chk("t6_no_ack", 0, 32'(last_ack[0][1] >= c0), 32'd0);
        for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 32'h30, 32'd0);
        wait_idle(20);
        chk("t6_rdata", 0, o_crd[0], 32'h0000ABCD);
        chk("t6_rdata", 1, o_crd[1], 32'h0000ABCD);

        // Randomized traffic
        mode = 2;
        for (int n = 0; n < 1500; n++) run_cycle(1'b0);
        mode = 0;
        wait_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
